button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter N, default 120000, meaning the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 12 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter ACTIVE_LOW, default 0, meaning 1 = button pin reads 0 when pressed.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port RSTN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port SW, input, 1 bit: raw asynchronous button pin.
REQ-006 SHALL have port PRESSED, output, 1 bit: debounced level, 1 = pressed.
REQ-007 SHALL have port PRESS_PULSE, output, 1 bit: one-cycle strobe on accepted press.
REQ-008 SHALL have port RELEASE_PULSE, output, 1 bit: one-cycle strobe on accepted release.
REQ-009 SHALL have port LED1, output, 1 bit: toggles once per accepted press.
REQ-010 SHALL have port LED2, output, 1 bit: always the complement of LED1.

Function
REQ-011 SHALL pass SW through a 2-flop synchronizer, then normalize: raw_n = sync XOR ACTIVE_LOW, 1 = pressed.
REQ-012 SHALL implement the FSM states UP, WAIT_DOWN, DOWN and WAIT_UP.
REQ-013 SHALL make these transitions: UP with raw_n=1 goes to WAIT_DOWN and counter=1; WAIT_DOWN with raw_n=0 goes back to UP and counter=0.
REQ-014 SHALL move WAIT_DOWN to DOWN when raw_n=1 and counter=N-1; otherwise counter+1.
REQ-015 SHALL mirror REQ-013/014 for DOWN, WAIT_UP and UP with raw_n inverted.
REQ-016 SHALL size the counter at clog2(N)+1 bits, make it saturation-free and have it never exceed N-1; it SHALL clear on every return to a stable state.
REQ-017 SHALL drive PRESSED=1 exactly in states DOWN and WAIT_UP, registered (no glitch while bouncing).
REQ-018 SHALL assert PRESS_PULSE for exactly the single cycle in which PRESSED first reads 1 after the WAIT_DOWN->DOWN edge; RELEASE_PULSE likewise for the WAIT_UP->UP edge.
REQ-019 SHALL never assert both pulses in the same cycle, and SHALL keep them separated by at least N cycles.
REQ-020 SHALL have latency: SW stable from before rising edge k gives raw_n valid after edge k+1, and PRESSED/pulse valid after edge k+N+1 (N+2 edges total).
REQ-021 SHALL reject bounce: any raw_n glitch shorter than N consecutive samples leaves PRESSED, the pulses and LED1 unchanged.
REQ-022 SHALL toggle LED1 on the same edge that asserts PRESS_PULSE; release SHALL not affect LED1.
REQ-023 SHALL restart WAIT_DOWN counting from 1 when a pressed sample follows a glitch back to UP; partial counts are not accumulated.

Reset
REQ-024 SHALL, while RSTN=0, immediately force: synchronizer flops to the not-pressed pin level (ACTIVE_LOW), state UP, counter 0, PRESSED=0, both pulses 0, LED1=0, LED2=1.
REQ-025 SHALL treat reset asserted mid-count or in DOWN as abandoning that state, with no pulse generated.
REQ-026 SHALL sample normally from the first rising CLK edge after RSTN deassertion; a button held through reset is accepted as a press after N+2 edges.

Verification (bench uses N=3, ACTIVE_LOW=0, clock period 84 ns)
REQ-027 SHALL cover: hold RSTN=0 with SW=1 -> PRESSED=0, LED1=0, LED2=1 during reset; release RSTN -> PRESS_PULSE high on exactly the 5th edge-cycle, LED1=1.
REQ-028 SHALL cover: clean press SW 0->1 held 10 cycles -> PRESSED rises 5 edges after the change, PRESS_PULSE high 1 cycle, LED1 0->1, LED2 1->0.
REQ-029 SHALL cover: bounce SW 1,0,1,0 one cycle each, then stable 0 -> no pulse, PRESSED stays 0, LED1 unchanged.
REQ-030 SHALL cover: glitch of 2 cycles (N-1) while pressed -> PRESSED stays 1, no RELEASE_PULSE; glitch of 3 cycles -> RELEASE_PULSE once, LED1 unchanged.
REQ-031 SHALL cover: four clean press/release pairs -> exactly 4 PRESS_PULSE and 4 RELEASE_PULSE, final LED1=0, LED2=1.
REQ-032 SHALL cover: RSTN pulsed low during WAIT_DOWN (counter=2) -> outputs return to reset values asynchronously, with no pulse.

Source files
------------

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Debounces a raw mechanical push-button. The pin is first brought into the
// CLK domain through a two-flop synchronizer. It is then normalized so that
// 1 means pressed. A four-state FSM accepts a level change only after N
// consecutive stable samples.
//
// Parameters
//   N          : consecutive stable samples needed to accept a change (2..2^24)
//   ACTIVE_LOW : 1 = pin reads 0 while the button is pressed
//
// Ports
//   CLK           : clock, all state updates on the rising edge
//   RSTN          : asynchronous active-low reset
//   SW            : raw asynchronous button pin
//   PRESSED       : debounced level, 1 = pressed (registered)
//   PRESS_PULSE   : one-cycle strobe when a press is accepted
//   RELEASE_PULSE : one-cycle strobe when a release is accepted
//   LED1          : toggles once per accepted press
//   LED2          : complement of LED1
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int N          = 120000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SW,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LED1,
  output logic LED2
);

  localparam int            CW       = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] ST_UP        = 2'd0;
  localparam logic [1:0] ST_WAIT_DOWN = 2'd1;
  localparam logic [1:0] ST_DOWN      = 2'd2;
  localparam logic [1:0] ST_WAIT_UP   = 2'd3;

  logic          sync_p0;
  logic          sync_p1;
  logic          raw_n;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          press_evt;
  logic          release_evt;

  // ---- stage p0/p1: two-flop synchronizer --------------------------------
  // The flops reset to the idle pin level, so a reset never fakes a press.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_p0 <= ACTIVE_LOW;
      sync_p1 <= ACTIVE_LOW;
    end else begin
      sync_p0 <= SW;
      sync_p1 <= sync_p0;
    end
  end

  assign raw_n = sync_p1 ^ ACTIVE_LOW;

  // ---- FSM next-state / stability counter ---------------------------------
  // The first differing sample loads the counter with 1. The N-th
  // consecutive sample (counter == N-1) commits the change. Any sample that
  // agrees with the stable level abandons the partial count. The counter
  // therefore never exceeds N-1.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      ST_UP: begin
        if (raw_n) begin
          state_nxt = ST_WAIT_DOWN;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT_DOWN: begin
        if (!raw_n) begin
          state_nxt = ST_UP;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_DOWN;
          cnt_nxt   = '0;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (!raw_n) begin
          state_nxt = ST_WAIT_UP;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT_UP: begin
        if (raw_n) begin
          state_nxt = ST_DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_UP;
          cnt_nxt     = '0;
          release_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_UP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- stage p2: FSM state and registered outputs -------------------------
  // PRESSED, both strobes and LED1 all update on the edge that commits a
  // transition, so they switch in the same cycle and never glitch.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= ST_UP;
      cnt           <= '0;
      PRESSED       <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LED1          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      PRESS_PULSE   <= press_evt;
      RELEASE_PULSE <= release_evt;
      if (press_evt) begin
        PRESSED <= 1'b1;
        LED1    <= ~LED1;
      end else if (release_evt) begin
        PRESSED <= 1'b0;
      end
    end
  end

  assign LED2 = ~LED1;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int TB_N = 3;
  localparam int LAT  = TB_N + 2;  // SW change at negedge c -> pulse seen at negedge c+LAT

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic SW = 1'b1;
  logic PRESSED;
  logic PRESS_PULSE;
  logic RELEASE_PULSE;
  logic LED1;
  logic LED2;

  button_debouncer #(.N(TB_N), .ACTIVE_LOW(1'b0)) dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .SW            (SW),
    .PRESSED       (PRESSED),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .LED1          (LED1),
    .LED2          (LED2)
  );

  always #42 CLK = ~CLK;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int   kind;  // 0 = press, 1 = release
    int   at;    // value of cyc at the negedge where the strobe must be seen
    logic led1;  // LED1 value required alongside the strobe
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int press_cnt = 0;
  int rel_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, want);
  endtask

  task automatic push(input int kind, input int at, input logic led1);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    e.led1 = led1;
    sb.push_back(e);
  endtask

  // Pulse monitor: every strobe must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (PRESS_PULSE === 1'b1 || RELEASE_PULSE === 1'b1) begin
      exp_t e;
      if (PRESS_PULSE === 1'b1) press_cnt++;
      if (RELEASE_PULSE === 1'b1) rel_cnt++;
      check("pulse_exclusive", 32'(PRESS_PULSE & RELEASE_PULSE), 32'd0);
      check("pulse_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_kind", 32'(RELEASE_PULSE), 32'(e.kind));
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("pulse_led1", 32'(LED1), 32'(e.led1));
      end
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int c;
    int p0;
    int r0;

    // Button held through reset: outputs must stay at reset values.
    negs(3);
    check("rst_pressed", 32'(PRESSED), 32'd0);
    check("rst_led1", 32'(LED1), 32'd0);
    check("rst_led2", 32'(LED2), 32'd1);
    check("rst_pulses", 32'({PRESS_PULSE, RELEASE_PULSE}), 32'd0);

    // Release reset with SW still high: press accepted on the 5th edge.
    RSTN = 1'b1;
    c = cyc;
    push(0, c + LAT, 1'b1);
    negs(LAT - 1);
    check("hold_pressed_early", 32'(PRESSED), 32'd0);
    negs(1);
    check("hold_pressed", 32'(PRESSED), 32'd1);
    check("hold_led2", 32'(LED2), 32'd0);
    negs(3);

    // Release.
    SW = 1'b0;
    c = cyc;
    push(1, c + LAT, 1'b1);
    negs(8);
    check("rel_pressed", 32'(PRESSED), 32'd0);
    check("rel_led1", 32'(LED1), 32'd1);

    // Reset asserted mid WAIT_DOWN (counter = 2): async clear, no pulse.
    SW = 1'b1;
    negs(4);
    RSTN = 1'b0;
    #1;
    check("async_led1", 32'(LED1), 32'd0);
    check("async_led2", 32'(LED2), 32'd1);
    check("async_pressed", 32'(PRESSED), 32'd0);
    SW = 1'b0;
    negs(2);
    RSTN = 1'b1;
    negs(8);
    check("after_rst_pressed", 32'(PRESSED), 32'd0);
    check("after_rst_led1", 32'(LED1), 32'd0);

    // Clean press held 10 cycles.
    SW = 1'b1;
    c = cyc;
    push(0, c + LAT, 1'b1);
    negs(LAT - 1);
    check("clean_pre_pressed", 32'(PRESSED), 32'd0);
    check("clean_pre_led2", 32'(LED2), 32'd1);
    negs(1);
    check("clean_pressed", 32'(PRESSED), 32'd1);
    check("clean_led1", 32'(LED1), 32'd1);
    check("clean_led2", 32'(LED2), 32'd0);
    negs(10 - LAT);

    // N-1 cycle glitch while pressed: rejected.
    SW = 1'b0;
    negs(TB_N - 1);
    SW = 1'b1;
    negs(8);
    check("glitch2_pressed", 32'(PRESSED), 32'd1);

    // N cycle low while pressed: accepted release, then re-press on return.
    SW = 1'b0;
    c = cyc;
    push(1, c + LAT, 1'b1);
    negs(TB_N);
    SW = 1'b1;
    c = cyc;
    push(0, c + LAT, 1'b0);
    negs(8);
    check("glitch3_pressed", 32'(PRESSED), 32'd1);
    check("glitch3_led1", 32'(LED1), 32'd0);
    SW = 1'b0;
    c = cyc;
    push(1, c + LAT, 1'b0);
    negs(8);
    check("glitch3_rel_pressed", 32'(PRESSED), 32'd0);

    // Bounce 1,0,1,0 then stable 0: nothing accepted.
    SW = 1'b1; negs(1);
    SW = 1'b0; negs(1);
    SW = 1'b1; negs(1);
    SW = 1'b0;
    negs(10);
    check("bounce_pressed", 32'(PRESSED), 32'd0);
    check("bounce_led1", 32'(LED1), 32'd0);

    // Four clean press/release pairs.
    p0 = press_cnt;
    r0 = rel_cnt;
    for (int i = 0; i < 4; i++) begin
      SW = 1'b1;
      c = cyc;
      push(0, c + LAT, (i % 2 == 0) ? 1'b1 : 1'b0);
      negs(8);
      SW = 1'b0;
      c = cyc;
      push(1, c + LAT, (i % 2 == 0) ? 1'b1 : 1'b0);
      negs(8);
    end
    check("pairs_press_cnt", 32'(press_cnt - p0), 32'd4);
    check("pairs_rel_cnt", 32'(rel_cnt - r0), 32'd4);
    check("pairs_led1", 32'(LED1), 32'd0);
    check("pairs_led2", 32'(LED2), 32'd1);

    negs(4);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
